// File: rtl/inc1_pkg.sv
// inc1_pkg -- shared constants and types for the inc1 incrementer.
//   INC1_WIDTH_DEFAULT : default operand/result width in bits
//   INC1_BLK           : width of one carry-lookahead block
//   inc1_word_t        : operand word at the default width
package inc1_pkg;

  localparam int INC1_WIDTH_DEFAULT = 24;
  localparam int INC1_BLK           = 4;

  typedef logic [INC1_WIDTH_DEFAULT-1:0] inc1_word_t;

endpackage

// File: rtl/inc1_blk4.sv
// inc1_blk4 -- one 4-bit incrementer block.
// The block is given its carry-in from outside and never receives carry from
// a neighbour. Each sum bit flips when the carry-in is set and every lower bit
// of the block is 1.
// Ports:
//   a   : 4-bit slice of the operand
//   ci  : block carry-in (cin AND all lower block propagates)
//   sum : incremented slice
//   p   : block propagate, AND of all four operand bits
module inc1_blk4
  import inc1_pkg::*;
(
  input  logic [INC1_BLK-1:0] a,
  input  logic                ci,
  output logic [INC1_BLK-1:0] sum,
  output logic                p
);

  assign sum[0] = a[0] ^ ci;
  assign sum[1] = a[1] ^ (ci & a[0]);
  assign sum[2] = a[2] ^ (ci & a[1] & a[0]);
  assign sum[3] = a[3] ^ (ci & a[2] & a[1] & a[0]);
  assign p      = &a;

endmodule

// File: rtl/inc1.sv
// inc1 -- WIDTH-bit incrementer {cout, inc} = a + cin with a registered copy.
// The combinational result uses a 4-bit block lookahead: each block's
// carry-in is cin AND the propagates of every lower block, so no carry ripples
// from block to block. The only state is the inc_q/cout_q capture register.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset of inc_q/cout_q
//   a      : unsigned operand
//   cin    : increment request (adds 0 or 1)
//   en     : capture enable for inc_q/cout_q
//   inc    : combinational a + cin modulo 2^WIDTH
//   cout   : combinational carry-out of a + cin
//   inc_q  : registered inc
//   cout_q : registered cout
module inc1
  import inc1_pkg::*;
#(
  parameter int WIDTH = INC1_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] inc,
  output logic             cout,
  output logic [WIDTH-1:0] inc_q,
  output logic             cout_q
);

  localparam int NBLK = WIDTH / INC1_BLK;

  logic [NBLK-1:0]  blk_p;
  logic [NBLK-1:0]  blk_ci;
  logic [WIDTH-1:0] inc_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] inc_p1;
  logic             cout_p1;

  // ---- stage p0: combinational lookahead increment ----
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    if (k == 0) begin : g_first
      assign blk_ci[k] = cin;
    end else begin : g_upper
      // Carry-in is formed directly from all lower propagates, not chained
      // through the neighbouring block.
      assign blk_ci[k] = cin & (&blk_p[k-1:0]);
    end

    inc1_blk4 u_blk (
      .a   (a[k*INC1_BLK +: INC1_BLK]),
      .ci  (blk_ci[k]),
      .sum (inc_p0[k*INC1_BLK +: INC1_BLK]),
      .p   (blk_p[k])
    );
  end

  // Carry out only when every bit of a is 1 and an increment is requested.
  assign cout_p0 = cin & (&blk_p);

  assign inc  = inc_p0;
  assign cout = cout_p0;

  // ---- stage p1: capture register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_p1  <= '0;
      cout_p1 <= 1'b0;
    end else if (en) begin
      inc_p1  <= inc_p0;
      cout_p1 <= cout_p0;
    end
  end

  assign inc_q  = inc_p1;
  assign cout_q = cout_p1;

endmodule

// File: tb/tb_inc1.sv
// tb_inc1 -- self-checking bench for inc1 at the default 24-bit width.
// Directed table of combinational vectors, hand-written register/reset
// sequences, then random (a, cin) pairs against a 25-bit reference sum.
module tb_inc1;

  localparam int W = 24;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic         cin;
  logic         en;
  logic [W-1:0] inc;
  logic         cout;
  logic [W-1:0] inc_q;
  logic         cout_q;

  int errors = 0;
  int checks = 0;

  inc1 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .cin    (cin),
    .en     (en),
    .inc    (inc),
    .cout   (cout),
    .inc_q  (inc_q),
    .cout_q (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         cin;
    logic [W-1:0] exp_inc;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_comb(input logic [W-1:0] av, input logic cv);
    a   = av;
    cin = cv;
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    logic [W:0]   ref_sum;
    logic [W-1:0] lowmask;

    vecs[0] = '{24'h123456, 1'b0, 24'h123456, 1'b0};
    vecs[1] = '{24'h000000, 1'b1, 24'h000001, 1'b0};
    vecs[2] = '{24'h123456, 1'b1, 24'h123457, 1'b0};
    vecs[3] = '{24'hAFFFFF, 1'b1, 24'hB00000, 1'b0};
    vecs[4] = '{24'hBFFFFF, 1'b1, 24'hC00000, 1'b0};
    vecs[5] = '{24'h00FFFF, 1'b1, 24'h010000, 1'b0};
    vecs[6] = '{24'hFFFFFF, 1'b0, 24'hFFFFFF, 1'b0};
    vecs[7] = '{24'hFFFFFF, 1'b1, 24'h000000, 1'b1};
    vecs[8] = '{24'h00000F, 1'b1, 24'h000010, 1'b0};
    vecs[9] = '{24'h7FFFFF, 1'b1, 24'h800000, 1'b0};

    // Reset asserted from time zero: registers cleared without a clock edge.
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    cin   = 1'b0;
    #1;
    check("reset_inc_q", 64'(inc_q), 64'h0);
    check("reset_cout_q", 64'(cout_q), 64'h0);

    // Combinational outputs work while reset is held.
    apply_comb(24'hFFFFFF, 1'b1);
    check("inreset_inc", 64'(inc), 64'h0);
    check("inreset_cout", 64'(cout), 64'h1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      apply_comb(vecs[i].a, vecs[i].cin);
      check($sformatf("vec%0d_inc", i), 64'(inc), 64'(vecs[i].exp_inc));
      check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].exp_cout));
    end

    // Register capture with one-cycle latency.
    @(negedge clk);
    rst_n = 1'b1;
    a = 24'h00FFFF; cin = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("load_inc_q", 64'(inc_q), 64'h010000);
    check("load_cout_q", 64'(cout_q), 64'h0);

    // Hold with en = 0 while the inputs change.
    @(negedge clk);
    en = 1'b0; a = 24'hFFFFFF; cin = 1'b1;
    @(posedge clk); #1;
    check("hold_inc_q", 64'(inc_q), 64'h010000);
    check("hold_cout_q", 64'(cout_q), 64'h0);

    // Load the wrap-around result.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("wrap_inc_q", 64'(inc_q), 64'h0);
    check("wrap_cout_q", 64'(cout_q), 64'h1);

    // Load a nonzero value, then reset mid-cycle.
    @(negedge clk);
    a = 24'h123456; cin = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_inc_q", 64'(inc_q), 64'h123457);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_inc_q", 64'(inc_q), 64'h0);
    check("midrst_cout_q", 64'(cout_q), 64'h0);
    check("midrst_inc_comb", 64'(inc), 64'h123457);

    // Capture carrying cout_q = 1, then reset again with en held high across
    // an edge: no capture happens while reset is low.
    @(negedge clk);
    rst_n = 1'b1;
    a = 24'hFFFFFF; cin = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("reload_cout_q", 64'(cout_q), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst2_cout_q", 64'(cout_q), 64'h0);
    a = 24'h00FFFF;
    @(posedge clk); #1;
    check("rst_edge_inc_q", 64'(inc_q), 64'h0);
    check("rst_edge_cout_q", 64'(cout_q), 64'h0);

    // After release, nothing loads until en = 1.
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("post_rst_hold", 64'(inc_q), 64'h0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    check("post_rst_load", 64'(inc_q), 64'h010000);
    @(negedge clk);
    en = 1'b0;

    // Random pairs, biased toward long runs of low-order ones.
    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] av;
      logic         cv;
      av = W'($urandom);
      cv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        lowmask = (W'(1) << (4 * $urandom_range(0, 6))) - W'(1);
        av = av | lowmask;
      end
      apply_comb(av, cv);
      ref_sum = {1'b0, av} + {{W{1'b0}}, cv};
      check("random", 64'({cout, inc}), 64'(ref_sum));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
